// File: rtl/dtree_pkg.sv
// dtree_pkg: parameter defaults, accumulator sizing and state encoding shared
// by the decision-tree datapath and its control sequencer.
package dtree_pkg;
    localparam int FEATURES         = 3;
    localparam int COEFF_BIT_DEPTH  = 4;
    localparam int BIAS_BIT_DEPTH   = 10;
    localparam int SAMPLE_BIT_DEPTH = 8;

    function automatic int acc_width(input int f, input int c, input int b, input int s);
        return ((b > s + c) ? b : s + c) + $clog2(f) + 1;
    endfunction

    localparam int ACC_BIT_DEPTH = acc_width(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH, SAMPLE_BIT_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_e;
endpackage

// File: rtl/node_mac.sv
// node_mac: per-cycle term selection (x, coeff*x or zero) and the
// bias-loaded running accumulator for one hyperplane node.
module node_mac #(
    parameter int COEFF_BIT_DEPTH  = dtree_pkg::COEFF_BIT_DEPTH,
    parameter int BIAS_BIT_DEPTH   = dtree_pkg::BIAS_BIT_DEPTH,
    parameter int SAMPLE_BIT_DEPTH = dtree_pkg::SAMPLE_BIT_DEPTH,
    parameter int ACC_BIT_DEPTH    = dtree_pkg::ACC_BIT_DEPTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               load_bias,
    input  logic                               zero_term,
    input  logic                               is_one,
    input  logic                               mult,
    input  logic signed [COEFF_BIT_DEPTH-1:0]  coeff,
    input  logic signed [SAMPLE_BIT_DEPTH-1:0] x,
    input  logic signed [BIAS_BIT_DEPTH-1:0]   bias,
    output logic signed [ACC_BIT_DEPTH-1:0]    acc
);
    localparam int PW = COEFF_BIT_DEPTH + SAMPLE_BIT_DEPTH;

    logic signed [PW-1:0]            prod;
    logic signed [ACC_BIT_DEPTH-1:0] x_ext, prod_ext, bias_ext, term, acc_d, acc_q;

    always_comb begin
        prod     = coeff * x;
        x_ext    = {{(ACC_BIT_DEPTH-SAMPLE_BIT_DEPTH){x[SAMPLE_BIT_DEPTH-1]}}, x};
        prod_ext = {{(ACC_BIT_DEPTH-PW){prod[PW-1]}}, prod};
        bias_ext = {{(ACC_BIT_DEPTH-BIAS_BIT_DEPTH){bias[BIAS_BIT_DEPTH-1]}}, bias};
        term     = zero_term ? '0 : is_one ? x_ext : mult ? prod_ext : '0;
        acc_d    = en ? (load_bias ? bias_ext : acc_q) + term : acc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/tree_node_datapath.sv
// tree_node_datapath: latches one spike's features and evaluates one
// hyperplane node per control burst, reporting the sign as child_direction.
module tree_node_datapath
    import dtree_pkg::*;
#(
    parameter int FEATURES         = dtree_pkg::FEATURES,
    parameter int COEFF_BIT_DEPTH  = dtree_pkg::COEFF_BIT_DEPTH,
    parameter int BIAS_BIT_DEPTH   = dtree_pkg::BIAS_BIT_DEPTH,
    parameter int SAMPLE_BIT_DEPTH = dtree_pkg::SAMPLE_BIT_DEPTH,
    parameter int ACC_BIT_DEPTH    = acc_width(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH, SAMPLE_BIT_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [FEATURES*SAMPLE_BIT_DEPTH-1:0]   feature_in,
    input  logic                                   feature_valid,
    output logic                                   feature_ready,
    input  logic                                   load_bias,
    input  logic                                   add,
    input  logic                                   mult,
    input  logic signed [COEFF_BIT_DEPTH-1:0]      coeff,
    input  logic                                   is_one,
    input  logic signed [BIAS_BIT_DEPTH-1:0]       bias,
    input  logic                                   out_valid,
    output logic                                   child_direction,
    output logic                                   next,
    output logic signed [ACC_BIT_DEPTH-1:0]        acc,
    output logic                                   seq_error
);
    localparam int IW = $clog2(FEATURES + 1);

    state_e                             state_q, state_d;
    logic                               ready_q, ready_d, next_q, next_d;
    logic                               err_q, err_d, child_q, child_d, added_q, added_d;
    logic [IW-1:0]                      idx_q, idx_d, sel;
    logic signed [SAMPLE_BIT_DEPTH-1:0] feat_q [FEATURES];
    logic signed [SAMPLE_BIT_DEPTH-1:0] feat_d [FEATURES];
    logic                               cap, do_add, over;

    always_comb begin
        cap     = (state_q == IDLE) && ready_q && feature_valid;
        do_add  = (state_q == EVAL) && add;
        over    = do_add && !load_bias && (idx_q == IW'(FEATURES));
        state_d = cap ? EVAL : ((state_q == EVAL) && out_valid) ? IDLE : state_q;
        ready_d = state_d == IDLE;
        next_d  = cap;
        idx_d   = cap ? '0 : !do_add ? idx_q : load_bias ? IW'(1) : over ? idx_q : IW'(idx_q + 1'b1);
        err_d   = err_q | over;
        added_d = do_add;
        child_d = (added_q && !do_add) ? ~acc[ACC_BIT_DEPTH-1] : child_q;
        // An exhausted index reads feature 0; its term is forced to zero anyway.
        sel     = (load_bias || idx_q >= IW'(FEATURES)) ? '0 : idx_q;
        feat_d  = feat_q;
        for (int i = 0; i < FEATURES; i++)
            if (cap) feat_d[i] = feature_in[(FEATURES-1-i)*SAMPLE_BIT_DEPTH +: SAMPLE_BIT_DEPTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            next_q  <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            child_q <= 1'b0;
            added_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            next_q  <= next_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            child_q <= child_d;
            added_q <= added_d;
        end
    end

    always_ff @(posedge clk) feat_q <= feat_d;

    node_mac #(
        .COEFF_BIT_DEPTH (COEFF_BIT_DEPTH),
        .BIAS_BIT_DEPTH  (BIAS_BIT_DEPTH),
        .SAMPLE_BIT_DEPTH(SAMPLE_BIT_DEPTH),
        .ACC_BIT_DEPTH   (ACC_BIT_DEPTH)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en       (do_add),
        .load_bias(load_bias),
        .zero_term(over),
        .is_one   (is_one),
        .mult     (mult),
        .coeff    (coeff),
        .x        (feat_q[sel]),
        .bias     (bias),
        .acc      (acc)
    );

    assign feature_ready   = ready_q;
    assign next            = next_q;
    assign seq_error       = err_q;
    assign child_direction = child_q;
endmodule

// File: tb/tb_tree_node_datapath.sv
// tb_tree_node_datapath: directed and randomized checks of tree_node_datapath
// against a plain-arithmetic node evaluation model.
module tb_tree_node_datapath;
    localparam int F = 3, C = 4, B = 10, S = 8, A = 15;

    logic                 clk = 1'b0, reset;
    logic [F*S-1:0]       feature_in;
    logic                 feature_valid, feature_ready, load_bias, add, mult, is_one, out_valid;
    logic signed [C-1:0]  coeff;
    logic signed [B-1:0]  bias;
    logic                 child_direction, next, seq_error;
    logic signed [A-1:0]  acc;

    int vecs = 0, errs = 0;
    int cur_x [F];

    tree_node_datapath dut (
        .clk(clk), .reset(reset), .feature_in(feature_in), .feature_valid(feature_valid),
        .feature_ready(feature_ready), .load_bias(load_bias), .add(add), .mult(mult),
        .coeff(coeff), .is_one(is_one), .bias(bias), .out_valid(out_valid),
        .child_direction(child_direction), .next(next), .acc(acc), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        feature_valid = 0; load_bias = 0; add = 0; mult = 0; is_one = 0;
        out_valid = 0; coeff = '0; bias = '0; feature_in = '0;
    endtask

    function automatic int model(input int b, input int m [F], input int cf [F], input int x [F]);
        int s = b;
        for (int i = 0; i < F; i++) s += (m[i] == 1) ? x[i] : (m[i] == 2) ? cf[i] * x[i] : 0;
        return s;
    endfunction

    task automatic capture(input int x0, input int x1, input int x2);
        vecs++;
        if (feature_ready !== 1'b1) begin errs++; $display("FAIL cap_ready_before: got %b want 1", feature_ready); end
        cur_x = '{x0, x1, x2};
        feature_in = {S'(x0), S'(x1), S'(x2)};
        feature_valid = 1;
        step();
        feature_valid = 0;
        vecs++;
        if (next !== 1'b1) begin errs++; $display("FAIL cap_next: got %b want 1", next); end
        vecs++;
        if (feature_ready !== 1'b0) begin errs++; $display("FAIL cap_ready_after: got %b want 0", feature_ready); end
        step();
        vecs++;
        if (next !== 1'b0) begin errs++; $display("FAIL next_width: got %b want 0", next); end
    endtask

    // Modes: 0 zero term, 1 coefficient +1, 2 coeff*x.
    task automatic run_node(input int b, input int m [F], input int cf [F], input bit ov_last);
        int exp = model(b, m, cf, cur_x);
        for (int i = 0; i < F; i++) begin
            add = 1; load_bias = (i == 0); bias = B'(b);
            is_one = (m[i] == 1);
            mult = (m[i] == 2) ? 1'b1 : (m[i] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            coeff = (m[i] == 2) ? C'(cf[i]) : C'($urandom_range(0, 15));
            out_valid = ov_last && (i == F - 1);
            if (out_valid) feature_valid = 0;
            step();
        end
        add = 0; load_bias = 0; out_valid = 0;
        vecs++;
        if (int'(acc) !== exp) begin errs++; $display("FAIL node_acc: got %0d want %0d", acc, exp); end
        step();
        vecs++;
        if (child_direction !== (exp >= 0)) begin errs++; $display("FAIL node_child: got %b want %b (acc %0d)", child_direction, exp >= 0, exp); end
        vecs++;
        if (next !== 1'b0) begin errs++; $display("FAIL no_recapture: got next %b want 0", next); end
        if (ov_last) begin
            vecs++;
            if (feature_ready !== 1'b1) begin errs++; $display("FAIL ov_add_ready: got %b want 1", feature_ready); end
        end
    endtask

    task automatic test_reset();
        quiet();
        reset = 0;
        step(); step();
        vecs++;
        if ({feature_ready, next, child_direction, seq_error} !== 4'b0) begin
            errs++; $display("FAIL reset_flags: got %b want 0000", {feature_ready, next, child_direction, seq_error});
        end
        vecs++;
        if (acc !== '0) begin errs++; $display("FAIL reset_acc: got %0d want 0", acc); end
        reset = 1;
        step();
        vecs++;
        if (feature_ready !== 1'b1) begin errs++; $display("FAIL reset_release_ready: got %b want 1", feature_ready); end
    endtask

    task automatic test_directed();
        int m [F];
        int cf [F];
        capture(10, -5, 3);
        m = '{1, 2, 2}; cf = '{0, 2, -1};
        run_node(-20, m, cf, 0);
        m = '{1, 1, 1};
        run_node(5, m, cf, 0);
        m = '{0, 0, 0}; cf = '{0, 0, 0};
        run_node(-1, m, cf, 0);
    endtask

    task automatic test_seq_error();
        logic signed [A-1:0] held = acc;
        add = 1; is_one = 1; load_bias = 0;
        step();
        add = 0; is_one = 0;
        vecs++;
        if (seq_error !== 1'b1) begin errs++; $display("FAIL seq_err_set: got %b want 1", seq_error); end
        vecs++;
        if (acc !== held) begin errs++; $display("FAIL seq_err_acc: got %0d want %0d", acc, held); end
        out_valid = 1;
        step();
        out_valid = 0;
        vecs++;
        if (seq_error !== 1'b1 || feature_ready !== 1'b1) begin
            errs++; $display("FAIL seq_err_hold: got err %b ready %b want 1 1", seq_error, feature_ready);
        end
        reset = 0;
        #1;
        vecs++;
        if (seq_error !== 1'b0) begin errs++; $display("FAIL seq_err_clear: got %b want 0", seq_error); end
        step();
        reset = 1;
        step();
    endtask

    task automatic test_reset_mid();
        int m [F];
        int cf [F];
        capture(-7, 20, 1);
        add = 1; load_bias = 1; is_one = 1; bias = B'(100);
        step();
        load_bias = 0; is_one = 0; mult = 1; coeff = C'(3);
        step();
        quiet();
        reset = 0;
        #1;
        vecs++;
        if (acc !== '0 || feature_ready !== 1'b0) begin
            errs++; $display("FAIL mid_reset: got acc %0d ready %b want 0 0", acc, feature_ready);
        end
        step();
        reset = 1;
        vecs++;
        if (feature_ready !== 1'b0) begin errs++; $display("FAIL mid_release_early: got %b want 0", feature_ready); end
        step();
        vecs++;
        if (feature_ready !== 1'b1) begin errs++; $display("FAIL mid_release_ready: got %b want 1", feature_ready); end
        capture(50, -60, 70);
        m = '{2, 1, 2}; cf = '{-8, 0, 7};
        run_node(-300, m, cf, 1);
    endtask

    task automatic test_random();
        int m [F];
        int cf [F];
        for (int s = 0; s < 12; s++) begin
            logic signed [A-1:0] held;
            logic                hold_child;
            capture(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128);
            feature_in = F*S'($urandom);
            feature_valid = 1;
            for (int n = 0; n < 3; n++) begin
                for (int i = 0; i < F; i++) begin
                    m[i] = int'($urandom_range(0, 2));
                    cf[i] = int'($urandom_range(0, 15)) - 8;
                end
                run_node(int'($urandom_range(0, 1023)) - 512, m, cf, (n == 2) && s[0]);
            end
            feature_valid = 0;
            if (!s[0]) begin
                out_valid = 1;
                step();
                out_valid = 0;
            end
            held = acc; hold_child = child_direction;
            add = 1; load_bias = 1; is_one = 1; bias = B'(200);
            step();
            quiet();
            step();
            vecs++;
            if (acc !== held || child_direction !== hold_child) begin
                errs++; $display("FAIL idle_ignore: got acc %0d child %b want %0d %b", acc, child_direction, held, hold_child);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_seq_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
